// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine that owns the HI/LO registers.
// MULT/MULTU use a shift-add datapath. DIV/DIVU use a restoring shift-subtract datapath.
// By default every operation takes WIDTH RUN cycles.
// Optional early-out build: define MULDIV_EARLY_OUT_EN. With it, a multiply stops once the
// remaining multiplier bits are all zero, and a divide skips the leading zeros of |a|.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;    // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opnd_q, opnd_d;  // |multiplicand| or |divisor|
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               qneg_q, qneg_d;  // product / quotient sign
   logic               rneg_q, rneg_d;  // remainder sign (dividend sign)
   logic               dz_q, dz_d;      // divide by zero: quotient forced to all ones
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   // per-step datapath signals
   logic               ready;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   sub;
   logic               ge;
   logic [2*WIDTH-1:0] acc_n;
   logic [2*WIDTH-1:0] acc_fin;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;
   logic               last;

`ifdef MULDIV_EARLY_OUT_EN
   logic [CW-1:0]      lz;

   // Leading-zero count, clamped to WIDTH-1 so at least one RUN step always runs.
   function automatic logic [CW-1:0] lead_zeros(input logic [WIDTH-1:0] v);
      lead_zeros = CW'(WIDTH-1);
      for (int i = 0; i < WIDTH; i++)
         if (v[i]) lead_zeros = CW'(WIDTH-1-i);
   endfunction
`endif

   assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;

   // Operand magnitudes and one radix-2 step of whichever operation is in flight.
   always_comb begin
      a_neg   = ~op[0] & a[WIDTH-1];
      b_neg   = ~op[0] & b[WIDTH-1];
      a_abs   = a_neg ? -a : a;
      b_abs   = b_neg ? -b : b;
      // multiply: add the multiplicand into the upper half if the multiplier LSB is set, then shift right
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      // divide: shift the next dividend bit into the remainder, then trial-subtract
      rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
      ge      = (rem_sh >= {1'b0, opnd_q});
      sub     = WIDTH'(rem_sh - {1'b0, opnd_q});
      if (is_div_q)
         acc_n = {(ge ? sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
      else
         acc_n = {mul_sum, acc_q[WIDTH-1:1]};
      last    = (cnt_q == '0);
      acc_fin = acc_n;
`ifdef MULDIV_EARLY_OUT_EN
      // The low cnt_q bits of acc_n are the unprocessed multiplier bits; once they are zero, the rest is a shift.
      if (!is_div_q && ((acc_n[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt_q)) == '0)) begin
         last    = 1'b1;
         acc_fin = acc_n >> cnt_q;
      end
`endif
      prod = qneg_q ? -acc_fin : acc_fin;
      quo  = dz_q ? '1 : (qneg_q ? -acc_fin[WIDTH-1:0] : acc_fin[WIDTH-1:0]);
      rem  = rneg_q ? -acc_fin[2*WIDTH-1:WIDTH] : acc_fin[2*WIDTH-1:WIDTH];
   end

   // Next-state control: accept start / MTHI / MTLO when ready, iterate in RUN, commit on the last step.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MULDIV_EARLY_OUT_EN
      lz       = lead_zeros(a_abs);
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               // start takes priority over a same-cycle MTHI/MTLO write
               state_d  = S_RUN;
               is_div_d = op[1];
               qneg_d   = a_neg ^ b_neg;
               rneg_d   = a_neg;
               dz_d     = op[1] & (b == '0);
               cnt_d    = CW'(WIDTH-1);
               if (op[1]) begin
                  opnd_d = b_abs;
`ifdef MULDIV_EARLY_OUT_EN
                  acc_d  = {{WIDTH{1'b0}}, a_abs << lz};
                  cnt_d  = CW'(WIDTH-1) - lz;
`else
                  acc_d  = {{WIDTH{1'b0}}, a_abs};
`endif
               end else begin
                  opnd_d = a_abs;
                  acc_d  = {{WIDTH{1'b0}}, b_abs};
               end
            end else begin
               if (wr_hi) hi_d = wd;
               if (wr_lo) lo_d = wd;
            end
         end
         S_RUN: begin
            acc_d = acc_n;
            cnt_d = cnt_q - CW'(1);
            if (last) begin
               state_d = S_DONE;
               if (is_div_q) begin
                  hi_d = rem;
                  lo_d = quo;
               end else begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any operation without committing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (default build, fixed WIDTH-cycle latency).
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a, b, wd;
   logic         wr_hi, wr_lo;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int errs = 0;
   int nchk = 0;
   int lat;

   muldiv_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present an op now (caller is off-edge); accepted at the next edge. Returns edges until done (0 = timeout).
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int n);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clock); #1;
      start = 1'b0; a = '0; b = '0;
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clock); #1;
         if (done) begin n = i; break; end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      @(negedge clock); reset = 1'b0;
      @(negedge clock);

      // 1: signed multiply, latency = 32 edges after the accepting edge (33rd cycle counting the start cycle)
      run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat);
      chk("mult_lat", lat, 32);
      chk("mult_hi", hi, 32'hFFFFFFFF);
      chk("mult_lo", lo, 32'hFFFFFFEB);
      @(negedge clock);

      // 2: unsigned multiply, busy low during done
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
      chk("multu_lat", lat, 32);
      chk("multu_busy_at_done", busy, 0);
      chk("multu_hi", hi, 32'hFFFFFFFE);
      chk("multu_lo", lo, 32'h00000001);
      @(negedge clock);

      // 3: signed divide, then DIVU issued directly from DONE
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat);
      chk("div_lat", lat, 32);
      chk("div_lo", lo, 32'hFFFFFFFD);
      chk("div_hi", hi, 32'hFFFFFFFF);
      run_op(2'b11, 32'd100, 32'd7, lat);
      chk("b2b_lat", lat, 32);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      @(negedge clock);

      // 4: divide by zero and signed overflow
      run_op(2'b11, 32'h64, 32'h0, lat);
      chk("dz_lat", lat, 32);
      chk("dz_hi", hi, 32'h64);
      chk("dz_lo", lo, 32'hFFFFFFFF);
      @(negedge clock);
      run_op(2'b10, 32'hFFFFFF9C, 32'h0, lat);
      chk("sdz_hi", hi, 32'hFFFFFF9C);
      chk("sdz_lo", lo, 32'hFFFFFFFF);
      @(negedge clock);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat);
      chk("ovf_lo", lo, 32'h80000000);
      chk("ovf_hi", hi, 32'h0);
      @(negedge clock);

      // 5: start and MTHI while busy are ignored; HI/LO hold during RUN
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
      @(posedge clock); #1;
      start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         start = (i == 5); a = 32'd9; b = 32'd9; op = 2'b01;
         wr_hi = (i == 8); wd = 32'hDEAD;
         @(posedge clock); #1;
         if (i == 9) begin
            chk("hold_hi", hi, 32'h0);
            chk("hold_lo", lo, 32'h80000000);
            chk("hold_busy", busy, 1);
         end
         if (done) begin lat = i; break; end
      end
      start = 1'b0; wr_hi = 1'b0;
      chk("ign_lat", lat, 32);
      chk("ign_hi", hi, 32'h0);
      chk("ign_lo", lo, 32'd30);
      @(negedge clock);
      wr_lo = 1'b1; wd = 32'h1234;
      @(posedge clock); #1;
      wr_lo = 1'b0;
      chk("mtlo_lo", lo, 32'h1234);
      chk("mtlo_hi", hi, 32'h0);
      @(negedge clock);
      wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hABCD;
      @(posedge clock); #1;
      wr_hi = 1'b0; wr_lo = 1'b0;
      chk("mtboth_hi", hi, 32'hABCD);
      chk("mtboth_lo", lo, 32'hABCD);
      @(negedge clock);

      // start with a same-cycle write: start wins
      wr_hi = 1'b1; wd = 32'h5555;
      run_op(2'b01, 32'd7, 32'd8, lat);
      wr_hi = 1'b0;
      chk("sw_hi", hi, 32'h0);
      chk("sw_lo", lo, 32'd56);
      @(negedge clock);
      wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'h77;
      @(posedge clock); #1;
      wr_hi = 1'b0; wr_lo = 1'b0;

      // 6: reset mid-divide clears everything at once, no done follows
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #1;
      chk("pre_rst_busy", busy, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_hi", hi, 0);
      chk("mid_rst_lo", lo, 0);
      @(negedge clock); reset = 1'b0;
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock); #1;
         if (done || busy) lat = i;
      end
      chk("no_done_after_rst", lat, 0);
      @(negedge clock);
      run_op(2'b01, 32'd3, 32'd4, lat);
      chk("post_rst_lat", lat, 32);
      chk("post_rst_lo", lo, 32'd12);
      chk("post_rst_hi", hi, 32'd0);
      @(posedge clock); #1;
      chk("done_one_cycle", done, 0);

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
